// File: rtl/debounce_enable_if.sv
// Signal bundle between the noisy-input conditioner and its consumer:
// the raw strobe in, and the clean level, edge pulses and busy flag out.
interface debounce_enable_if;
    logic raw;
    logic level;
    logic rise;
    logic fall;
    logic busy;

    modport master (output raw, input level, input rise, input fall, input busy);
    modport slave  (input raw, output level, output rise, output fall, output busy);
endinterface

// File: rtl/debounce_enable.sv
// Synchronises and debounces a noisy asynchronous input, producing a clean
// registered level plus single-cycle rise/fall pulses for an enable flop.
module debounce_enable #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_WIDTH    = 4,
    parameter int STABLE_COUNT = 10
) (
    input logic              clk,
    input logic              reset,
    debounce_enable_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   raw_s;
    logic                   commit_s;
    logic                   busy_s;

    assign raw_s  = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.raw};

    // State register: synchroniser, FSM state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: qualify a candidate change and commit it when stable
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (raw_s != level_q) begin
                    // A one-sample qualification commits without entering CHECK
                    if (STABLE_COUNT == 1) begin
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_CHECK: begin
                if (raw_s == level_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        if (commit_s) begin
            level_d = raw_s;
            rise_d  = raw_s;
            fall_d  = ~raw_s;
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
        end else begin
            level_d = level_q;
        end
    end

    // Output decode: busy comes from the state register alone
    always_comb begin
        busy_s = 1'b0;
        if (state_q == ST_CHECK) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.busy  = busy_s;
endmodule
